sram_wb_port_ctrl: RTL

Wishbone slave that sits directly upstream of the two OpenRAM macros in the user area: the 1 KB 32x256 "SRAM1" and the 2 KB 32x512 "SRAM12". It decodes Caravel Wishbone accesses into macro port-0 read/write cycles and returns read data with ack. Optionally, it drives port 1 in parallel to cross-check the dual-port read paths. It replaces ad-hoc LA-driven SRAM control as the normal access path from the management core.

---
 rtl/sram_wb_port_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_wb_port_ctrl.sv
// Wishbone slave that turns Caravel bus cycles into port-0 accesses on the SRAM1 (32x256) and
// SRAM12 (32x512) OpenRAM macros. Define SRAM_PORT_COMPARE_EN to read port 1 in parallel and flag mismatches.
module sram_wb_port_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        csbA0,
  output logic        csbA1,
  output logic        csbB0,
  output logic        csbB1,
  output logic        webA,
  output logic        webB,
  output logic [3:0]  wmaskA,
  output logic [3:0]  wmaskB,
  output logic [7:0]  addrA0,
  output logic [7:0]  addrA1,
  output logic [8:0]  addrB0,
  output logic [8:0]  addrB1,
  output logic [31:0] dinA0,
  output logic [31:0] dinB0,
  input  logic [31:0] sram1_dout0,
  input  logic [31:0] sram1_dout1,
  input  logic [31:0] sram12_dout0,
  input  logic [31:0] sram12_dout1,
  output logic        cmp_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {TGT_SRAM1, TGT_SRAM12, TGT_STATUS} target_t;

  state_t      state, state_next;
  target_t     req_target, target;
  logic        in_window, request, is_write;
  logic        accept, capture, status_read, status_clear, compare_strobe;
  logic [31:0] status_word;
  logic [31:0] sel_dout0;
  logic        unused_addr_bits;

  assign in_window = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  // A request is never taken while the previous ack is still on the bus.
  assign request   = wbs_stb_i && wbs_cyc_i && in_window && !wbs_ack_o;
  assign unused_addr_bits = ^wbs_adr_i[1:0];

  always_comb begin
    req_target = TGT_STATUS;
    if (wbs_adr_i[11])
      req_target = TGT_SRAM12;
    else if (!wbs_adr_i[10])
      req_target = TGT_SRAM1;
  end

  assign sel_dout0 = (target == TGT_SRAM12) ? sram12_dout0 : sram1_dout0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request) state_next = ISSUE;
      ISSUE: begin
        if (!wbs_cyc_i)
          state_next = IDLE;
        else if (is_write || target == TGT_STATUS)
          state_next = ACK;
        else
          state_next = WAIT;
      end
      WAIT:    state_next = wbs_cyc_i ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status accesses take effect in ISSUE; a dropped cycle still commits them, like a macro access.
  always_comb begin
    accept         = 1'b0;
    capture        = 1'b0;
    status_read    = 1'b0;
    status_clear   = 1'b0;
    compare_strobe = 1'b0;
    case (state)
      IDLE:  accept = request;
      ISSUE: begin
        status_read  = (target == TGT_STATUS) && !is_write && wbs_cyc_i;
        status_clear = (target == TGT_STATUS) && is_write;
      end
      WAIT: begin
        capture        = wbs_cyc_i;
        compare_strobe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      csbA0     <= 1'b1;
      csbB0     <= 1'b1;
      webA      <= 1'b1;
      webB      <= 1'b1;
      wmaskA    <= '0;
      wmaskB    <= '0;
      addrA0    <= '0;
      addrB0    <= '0;
      dinA0     <= '0;
      dinB0     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      target    <= TGT_SRAM1;
      is_write  <= 1'b0;
    end else begin
      wbs_ack_o <= (state_next == ACK);
      csbA0     <= 1'b1;
      csbB0     <= 1'b1;
      webA      <= 1'b1;
      webB      <= 1'b1;
      if (accept) begin
        target   <= req_target;
        is_write <= wbs_we_i;
        if (req_target == TGT_SRAM1) begin
          csbA0  <= 1'b0;
          webA   <= ~wbs_we_i;
          wmaskA <= wbs_sel_i;
          addrA0 <= wbs_adr_i[9:2];
          dinA0  <= wbs_dat_i;
        end
        if (req_target == TGT_SRAM12) begin
          csbB0  <= 1'b0;
          webB   <= ~wbs_we_i;
          wmaskB <= wbs_sel_i;
          addrB0 <= wbs_adr_i[10:2];
          dinB0  <= wbs_dat_i;
        end
      end
      if (capture)
        wbs_dat_o <= sel_dout0;
      else if (status_read)
        wbs_dat_o <= status_word;
    end
  end

`ifdef SRAM_PORT_COMPARE_EN
  logic [31:0] sel_dout1;
  logic [15:0] cmp_cnt;
  logic        mismatch;

  assign sel_dout1 = (target == TGT_SRAM12) ? sram12_dout1 : sram1_dout1;
  assign mismatch  = compare_strobe && (sel_dout0 != sel_dout1);

  // Port 1 shadows port 0 on memory reads only, so both read paths see the same word.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      csbA1  <= 1'b1;
      csbB1  <= 1'b1;
      addrA1 <= '0;
      addrB1 <= '0;
    end else begin
      csbA1 <= 1'b1;
      csbB1 <= 1'b1;
      if (accept && !wbs_we_i && req_target == TGT_SRAM1) begin
        csbA1  <= 1'b0;
        addrA1 <= wbs_adr_i[9:2];
      end
      if (accept && !wbs_we_i && req_target == TGT_SRAM12) begin
        csbB1  <= 1'b0;
        addrB1 <= wbs_adr_i[10:2];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmp_err_o <= 1'b0;
      cmp_cnt   <= '0;
    end else if (status_clear) begin
      cmp_err_o <= 1'b0;
      cmp_cnt   <= '0;
    end else if (mismatch) begin
      cmp_err_o <= 1'b1;
      if (cmp_cnt != 16'hFFFF)
        cmp_cnt <= cmp_cnt + 16'd1;
    end
  end

  assign status_word = {cmp_err_o, 15'b0, cmp_cnt};
`else
  logic unused_compare;

  assign csbA1          = 1'b1;
  assign csbB1          = 1'b1;
  assign addrA1         = '0;
  assign addrB1         = '0;
  assign cmp_err_o      = 1'b0;
  assign status_word    = '0;
  assign unused_compare = ^{sram1_dout1, sram12_dout1, status_clear, compare_strobe};
`endif

endmodule
